// File: rtl/rr_mux_scheduler.sv
// rr_mux_scheduler: round-robin arbiter driving a shared 16:1 bit mux with bounded hold per grant
module rr_mux_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] din,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        f,
  output logic        f_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d, cnt_q, cnt_d, sel_q, sel_d, win;
  logic [15:0] gnt_q, gnt_d;
  logic        xfer, release_now;
  // Scan downward so the last hit is the nearest request at or above ptr.
  always_comb begin
    win = '0;
    for (int i = 15; i >= 0; i--)
      if (req[ptr_q + 4'(i)]) win = ptr_q + 4'(i);
  end
  assign f_valid     = !rst && state_q == GRANT && req[sel_q];
  assign f           = f_valid && din[sel_q];
  assign xfer        = f_valid && out_ready;
  assign release_now = !req[sel_q] || (xfer && cnt_q + 4'd1 == 4'(MAX_HOLD));
  assign sel         = sel_q;
  assign gnt         = gnt_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        sel_d   = win;
        gnt_d   = 16'd1 << win;
        cnt_d   = '0;
      end
    end else if (release_now) begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
      ptr_d   = sel_q + 4'd1;
    end else if (xfer) begin
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule

// File: tb/tb_rr_mux_scheduler.sv
// tb_rr_mux_scheduler: directed scenarios feeding grant/transfer scoreboards checked by a negedge monitor
module tb_rr_mux_scheduler;
  logic        clk = 0, rst = 1, out_ready = 0, done = 0, rst_s = 1;
  logic [15:0] req = '0, din = '0, gnt, prev_gnt = '0;
  logic [3:0]  sel;
  logic        f, f_valid;
  logic [15:0] gq[$];
  logic [4:0]  xq[$];
  int          passed = 0, total = 0;

  rr_mux_scheduler #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .f(f), .f_valid(f_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_s <= rst;

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask

  // Monitor: pops expected grant changes and transfers, and checks output invariants each cycle.
  always @(negedge clk) begin
    logic [15:0] eg;
    logic [4:0]  ex;
    chk("gnt_onehot_sel", gnt & ~(16'd1 << sel), 16'h0);
    chk("f_valid", {15'd0, f_valid}, {15'd0, !rst && gnt != 0 && req[sel]});
    chk("f", {15'd0, f}, {15'd0, f_valid && din[sel]});
    if (rst_s) begin
      chk("rst_gnt", gnt, 16'h0);
      chk("rst_sel", {12'd0, sel}, 16'h0);
    end
    if (gnt !== prev_gnt) begin
      if (gq.size() == 0) begin
        total++;
        $display("FAIL gnt_unexpected: got %h expected no change from %h", gnt, prev_gnt);
      end else begin
        eg = gq.pop_front();
        chk("gnt_seq", gnt, eg);
      end
      prev_gnt = gnt;
    end
    if (f_valid && out_ready) begin
      if (xq.size() == 0) begin
        total++;
        $display("FAIL xfer_unexpected: got sel=%0d f=%0d expected none", sel, f);
      end else begin
        ex = xq.pop_front();
        chk("xfer_sel_f", {11'd0, sel, f}, {11'd0, ex});
      end
    end
    if (done) begin
      chk("gq_drained", 16'(gq.size()), 16'h0);
      chk("xq_drained", 16'(xq.size()), 16'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_g(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    gq.push_back(a); gq.push_back(b); gq.push_back(c); gq.push_back(d);
  endtask

  task automatic push_x(input logic [3:0] s, input logic v, input int n);
    repeat (n) xq.push_back({s, v});
  endtask

  initial begin
    step(2);
    // Single requester: 4 transfers, bubble, re-grant, drop after one transfer.
    push_g(16'h0001, 16'h0000, 16'h0001, 16'h0000);
    push_x(4'd0, 1'b1, 5);
    rst = 0; req = 16'h0001; din = 16'h0001; out_ready = 1;
    step(7); req = '0; step(2);
    // Alternation 0,15,0,15 from ptr=0.
    rst = 1; step(1);
    push_g(16'h0001, 16'h0000, 16'h8000, 16'h0000);
    push_g(16'h0001, 16'h0000, 16'h8000, 16'h0000);
    push_x(4'd0, 1'b0, 4); push_x(4'd15, 1'b1, 4); push_x(4'd0, 1'b0, 4); push_x(4'd15, 1'b1, 3);
    rst = 0; req = 16'h8001; din = 16'h8000;
    step(19); req = '0; step(2);
    // Grant 14, late requests 0 and 1 do not preempt; wrap picks 0.
    push_g(16'h4000, 16'h0000, 16'h0001, 16'h0000);
    push_x(4'd14, 1'b1, 4);
    req = 16'h4000; din = 16'h4000;
    step(1); req = 16'h4003; step(5); req = '0; step(2);
    // Grant 5 stalled 10 cycles, then 4 transfers while other din bits toggle.
    gq.push_back(16'h0020); gq.push_back(16'h0000);
    push_x(4'd5, 1'b1, 4);
    req = 16'h0020; din = 16'h0020; out_ready = 0;
    step(1);
    for (int i = 0; i < 10; i++) begin din = 16'($urandom) | 16'h0020; step(1); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin din = 16'($urandom) | 16'h0020; step(1); end
    req = '0; din = '0; step(2);
    // Grant 3 dropped after 2 transfers; ptr becomes 4 so 4 beats 3.
    push_g(16'h0008, 16'h0000, 16'h0010, 16'h0000);
    push_x(4'd3, 1'b0, 2);
    req = 16'h0008;
    step(3); req = '0; step(1); req = 16'h0018; step(1); req = '0; step(2);
    // Reset mid-grant at cnt=2, then arbitration restarts from ptr=0.
    push_g(16'h0004, 16'h0000, 16'h0100, 16'h0000);
    push_x(4'd2, 1'b1, 2);
    req = 16'h0004; din = 16'h0004;
    step(3); rst = 1; step(1); rst = 0; req = 16'h0100; step(1); req = '0; step(2);
    done = 1;
    step(3);
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1);
  end
endmodule
